bfly_addsub_stage: RTL

- Pipelined radix-2 butterfly add/subtract stage for the 64-point FFT datapath. It consumes already-twiddled complex operands A and B and produces X = A+B and Y = A−B.
- All four real additions and subtractions use the 16-bit Kogge-Stone adder `ksa_top` (ports: c0, a, b, s, c32). Subtraction is formed as a + ~b with c0=1.
- Optional divide-by-2 scaling per stage prevents word growth across the 6 FFT stages.
- Valid/ready handshake on both sides; the block sits between the twiddle multiplier and the stage memory write port.

---
 rtl/bfly_pkg.sv | 20 ++
 rtl/bfly_addsub_lane.sv | 68 ++++++
 rtl/ksa_top.sv | 46 ++++
 rtl/bfly_addsub_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bfly_pkg.sv
// Shared types and constants for the radix-2 butterfly add/subtract stage.
package bfly_pkg;

  localparam int BFLY_WIDTH = 16;
  localparam int LATENCY    = 2;

  typedef struct packed {
    logic signed [BFLY_WIDTH-1:0] re;
    logic signed [BFLY_WIDTH-1:0] im;
  } cplx_t;

  function automatic cplx_t mk_cplx(input logic [BFLY_WIDTH-1:0] re,
                                    input logic [BFLY_WIDTH-1:0] im);
    cplx_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

endpackage

// File: rtl/bfly_addsub_lane.sv
// One real butterfly lane: x = a+b, y = a-b with optional halving.
// Macro BFLY_ROUND_EN selects round-half-up instead of floor when SCALE=1.
module bfly_addsub_lane
  import bfly_pkg::*;
#(
  parameter int WIDTH = BFLY_WIDTH,
  parameter int SCALE = 1
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic                    ovf_o
);

`ifdef BFLY_ROUND_EN
  localparam logic ROUND = 1'b1;
`else
  localparam logic ROUND = 1'b0;
`endif

  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] s_add;
  logic [WIDTH-1:0] s_sub;
  logic             c_add;
  logic             c_sub;
  logic             t_add;
  logic             t_sub;

  assign b_inv = ~b_i;

  ksa_top #(.WIDTH(WIDTH)) u_add (
    .c0  (1'b0),
    .a   (a_i),
    .b   (b_i),
    .s   (s_add),
    .c32 (c_add)
  );

  ksa_top #(.WIDTH(WIDTH)) u_sub (
    .c0  (1'b1),
    .a   (a_i),
    .b   (b_inv),
    .s   (s_sub),
    .c32 (c_sub)
  );

  // t is bit WIDTH of the sign-extended (WIDTH+1)-bit result
  assign t_add = a_i[WIDTH-1] ^ b_i[WIDTH-1]   ^ c_add;
  assign t_sub = a_i[WIDTH-1] ^ b_inv[WIDTH-1] ^ c_sub;

  generate
    if (SCALE == 1) begin : g_scale
      logic [WIDTH-1:0] fx;
      logic [WIDTH-1:0] fy;
      assign fx    = {t_add, s_add[WIDTH-1:1]};
      assign fy    = {t_sub, s_sub[WIDTH-1:1]};
      assign x_o   = fx + {{(WIDTH-1){1'b0}}, s_add[0] & ROUND};
      assign y_o   = fy + {{(WIDTH-1){1'b0}}, s_sub[0] & ROUND};
      assign ovf_o = 1'b0;
    end else begin : g_wrap
      assign x_o   = s_add;
      assign y_o   = s_sub;
      assign ovf_o = (t_add ^ s_add[WIDTH-1]) | (t_sub ^ s_sub[WIDTH-1]);
    end
  endgenerate

endmodule

// File: rtl/ksa_top.sv
// Kogge-Stone parallel-prefix adder: {c32, s} = a + b + c0.
module ksa_top #(
  parameter int WIDTH = 16
) (
  input  logic             c0,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             c32
);

  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g_pre;
  logic [WIDTH-1:0] p_pre;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH:0]   c;

  assign p0 = a ^ b;

  // log2(WIDTH) prefix levels; after the tree g_pre[i]/p_pre[i] span bits [i:0]
  always_comb begin
    g_pre = a & b;
    p_pre = p0;
    g_nxt = g_pre;
    p_nxt = p_pre;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      g_nxt = g_pre;
      p_nxt = p_pre;
      for (int i = d; i < WIDTH; i++) begin
        g_nxt[i] = g_pre[i] | (p_pre[i] & g_pre[i-d]);
        p_nxt[i] = p_pre[i] & p_pre[i-d];
      end
      g_pre = g_nxt;
      p_pre = p_nxt;
    end
    c[0] = c0;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g_pre[i] | (p_pre[i] & c0);
    end
  end

  assign s   = p0 ^ c[WIDTH-1:0];
  assign c32 = c[WIDTH];

endmodule

// File: rtl/bfly_addsub_stage.sv
// Two-stage pipelined radix-2 butterfly (X=A+B, Y=A-B) with valid/ready on both sides.
// Rounding mode is selected by macro BFLY_ROUND_EN inside bfly_addsub_lane.
module bfly_addsub_stage
  import bfly_pkg::*;
#(
  parameter int WIDTH = BFLY_WIDTH,
  parameter int SCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_re,
  output logic signed [WIDTH-1:0] x_im,
  output logic signed [WIDTH-1:0] y_re,
  output logic signed [WIDTH-1:0] y_im,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  logic  s1_valid_q, s1_valid_d;
  logic  s2_valid_q, s2_valid_d;
  cplx_t s1_a_q, s1_a_d;
  cplx_t s1_b_q, s1_b_d;
  cplx_t s2_x_q, s2_x_d;
  cplx_t s2_y_q, s2_y_d;
  logic  ovf_q, ovf_d;

  logic  s1_adv;
  logic  s2_adv;
  logic  s2_load;
  cplx_t sum_x;
  cplx_t sum_y;
  logic  ovf_re;
  logic  ovf_im;

  bfly_addsub_lane #(.WIDTH(WIDTH), .SCALE(SCALE)) u_lane_re (
    .a_i   (s1_a_q.re),
    .b_i   (s1_b_q.re),
    .x_o   (sum_x.re),
    .y_o   (sum_y.re),
    .ovf_o (ovf_re)
  );

  bfly_addsub_lane #(.WIDTH(WIDTH), .SCALE(SCALE)) u_lane_im (
    .a_i   (s1_a_q.im),
    .b_i   (s1_b_q.im),
    .x_o   (sum_x.im),
    .y_o   (sum_y.im),
    .ovf_o (ovf_im)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign s2_load  = s2_adv && s1_valid_q;
  assign in_ready = s1_adv;

  // Next-state for both pipeline stages and the sticky overflow flag
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    s2_y_d     = s2_y_q;
    ovf_d      = ovf_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d = mk_cplx(a_re, a_im);
        s1_b_d = mk_cplx(b_re, b_im);
      end else begin
        s1_a_d = s1_a_q;
        s1_b_d = s1_b_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (s2_load) begin
      s2_x_d = sum_x;
      s2_y_d = sum_y;
    end else begin
      s2_x_d = s2_x_q;
      s2_y_d = s2_y_q;
    end

    // a fresh overflow beats a simultaneous clear
    if (s2_load && (ovf_re || ovf_im)) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pipeline and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_a_q     <= {(2*BFLY_WIDTH){1'b0}};
      s1_b_q     <= {(2*BFLY_WIDTH){1'b0}};
      s2_x_q     <= {(2*BFLY_WIDTH){1'b0}};
      s2_y_q     <= {(2*BFLY_WIDTH){1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_x_q     <= s2_x_d;
      s2_y_q     <= s2_y_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign x_re      = s2_x_q.re;
  assign x_im      = s2_x_q.im;
  assign y_re      = s2_y_q.re;
  assign y_im      = s2_y_q.im;
  assign ovf       = ovf_q;

endmodule
